// File: rtl/uart_byte_receiver.sv
// UART 8N1 byte receiver: synchronizes RxD, samples mid-bit, and holds the last good byte
// until acknowledged. Flags bad stop bits (pulse) and bytes lost while a byte was pending (sticky).
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  input  logic       rx_ack,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  // Preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !rx_ack;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            // A same-cycle ack means the old byte was consumed, so nothing is lost.
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ack) ovr_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data      = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: directed frames plus random frames checked against a
// frame-level model (byte lands at end of frame, ack consumes, loss sets sticky overrun).
module tb_uart_byte_receiver;
  localparam int CPB = 16;

  logic       clk = 1'b0, rst_n = 1'b0, RxD = 1'b1, rx_ack = 1'b0;
  logic [7:0] data;
  logic       rx_valid, frame_err, overrun, busy;

  int n_chk = 0, n_err = 0, ferr_seen = 0;
  logic [7:0] m_data = 8'h00;
  bit  m_valid = 0, m_ovr = 0;
  int  m_ferr = 0;
  int  lat;

  uart_byte_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .RxD(RxD), .rx_ack(rx_ack),
    .data(data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // One-cycle pulses are seen at exactly one falling edge; wider pulses overcount.
  always @(negedge clk) if (frame_err) ferr_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rst(input string tag);
    check({tag, ".data"}, 32'(data), 32'h0);
    check({tag, ".valid"}, 32'(rx_valid), 32'h0);
    check({tag, ".ferr"}, 32'(frame_err), 32'h0);
    check({tag, ".ovr"}, 32'(overrun), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    m_data = 8'h00; m_valid = 0; m_ovr = 0;
  endtask

  task automatic chk_model(input string tag);
    check({tag, ".data"}, 32'(data), 32'(m_data));
    check({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".ferrs"}, 32'(ferr_seen), 32'(m_ferr));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst(tag);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic do_ack;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_valid = 0;
  endtask

  // Frame-level model: a good stop delivers the byte; a pending unacked byte is lost.
  task automatic model_frame(input logic [7:0] b, input bit good, input bit acked);
    if (good) begin
      if (m_valid && !acked) m_ovr = 1;
      m_data  = b;
      m_valid = 1;
    end else begin
      m_ferr++;
    end
  endtask

  // Drives one 10-bit frame starting at c=0; optional ack at cycle ack_at and reset at rst_at.
  // lat returns the cycle at which rx_valid rose (-1 if it did not).
  task automatic send_frame(input logic [7:0] b, input bit stop, input int ack_at,
                            input int rst_at, output int lat_o);
    logic [9:0] fr;
    bit pv;
    fr    = {stop, b, 1'b0};
    pv    = rx_valid;
    lat_o = -1;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c > 0 && rx_valid && !pv && lat_o < 0) lat_o = c;
      pv     = rx_valid;
      RxD    = fr[c / CPB];
      rx_ack = (c == ack_at);
      if (rst_at >= 0 && c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_rst("midrst");
      end
      if (rst_at >= 0 && c == rst_at + 2) rst_n = 1'b1;
      @(negedge clk);
    end
    rx_ack = 1'b0;
  endtask

  initial begin
    do_reset("reset");

    // First byte: exact landing cycle and ack clearing.
    send_frame(8'hA5, 1'b1, -1, -1, lat);
    model_frame(8'hA5, 1, 0);
    check("a5.lat", 32'(lat), 32'd155);
    chk_model("a5");
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("a5.ackclr", 32'(rx_valid), 32'h0);
    m_valid = 0;

    // Short low glitch is rejected at the start-bit sample.
    RxD = 1'b0;
    cyc(4);
    check("glitch.busy_hi", 32'(busy), 32'h1);
    cyc(1);
    RxD = 1'b1;
    cyc(10);
    check("glitch.busy_lo", 32'(busy), 32'h0);
    chk_model("glitch");

    // Bad stop bit, line held low (break), then a clean byte.
    send_frame(8'h3C, 1'b0, -1, -1, lat);
    model_frame(8'h3C, 0, 0);
    cyc(40);
    check("brk.busy", 32'(busy), 32'h1);
    chk_model("brk");
    RxD = 1'b1;
    cyc(5);
    check("brk.idle", 32'(busy), 32'h0);
    send_frame(8'h55, 1'b1, -1, -1, lat);
    model_frame(8'h55, 1, 0);
    chk_model("after_brk");
    do_ack;

    // Back-to-back frames without ack overrun.
    send_frame(8'h11, 1'b1, -1, -1, lat);
    model_frame(8'h11, 1, 0);
    send_frame(8'h22, 1'b1, -1, -1, lat);
    model_frame(8'h22, 1, 0);
    chk_model("b2b");
    check("b2b.ovr_set", 32'(overrun), 32'h1);

    // Reset during data bit 4 aborts the frame and clears everything.
    send_frame(8'hF0, 1'b1, -1, 5 * CPB + 8, lat);
    check("midrst.busy", 32'(busy), 32'h0);
    chk_model("midrst_end");
    cyc(3);
    send_frame(8'hF0, 1'b1, -1, -1, lat);
    model_frame(8'hF0, 1, 0);
    chk_model("f0");

    // Ack in the landing cycle of the second byte: no overrun.
    send_frame(8'h11, 1'b1, -1, -1, lat);
    model_frame(8'h11, 1, 0);
    send_frame(8'h22, 1'b1, 154, -1, lat);
    model_frame(8'h22, 1, 1);
    chk_model("ackland");
    do_ack;
    chk_model("ackland_clr");

    // Random frames, random acks (including acks with nothing pending) and gaps.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      bit good;
      if ($urandom_range(1) == 1) do_ack;
      b    = 8'($urandom);
      good = ($urandom_range(4) != 0);
      send_frame(b, good, -1, -1, lat);
      if (!good) begin
        cyc($urandom_range(30));
        RxD = 1'b1;
        cyc(4);
      end
      model_frame(b, good, 0);
      cyc($urandom_range(20));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
